sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8-bit/16-entry byte buffer.
- Configurable data width and depth.
- Adds occupancy count, almost-full/almost-empty thresholds, overflow/underflow error pulses and defined simultaneous read/write behaviour.
- Sits between a bursty producer and a consumer that can stall for several cycles.

Parameters:
- DATA_W, 8, data bus width in bits (>=1).
- DEPTH, 16, number of entries; must be a power of two, >=4.
- AF_LEVEL, 14, almost_full asserts when fill_count >= AF_LEVEL (1..DEPTH-1).
- AE_LEVEL, 2, almost_empty asserts when fill_count <= AE_LEVEL (0..DEPTH-2).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- write_en  input  1  write request.
- data_in  input  DATA_W  write data.
- read_en  input  1  read request.
- data_out  output  DATA_W  read data.
- fifo_full  output  1  fill_count == DEPTH.
- fifo_empty  output  1  fill_count == 0.
- almost_full  output  1  fill_count >= AF_LEVEL.
- almost_empty  output  1  fill_count <= AE_LEVEL.
- fill_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write requested but rejected.
- underflow  output  1  one-cycle pulse: read requested but rejected.

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clock. All state updates on posedge clock; nonblocking assignments only.
- Reset values:
  - read and write pointers = 0, fill_count = 0
  - fifo_empty = 1, fifo_full = 0, almost_empty = 1, almost_full = 0
  - data_out = 0, overflow = 0, underflow = 0
  - Storage array is not reset; its contents are not observable until written.
  - Reset overrides any simultaneous read_en/write_en. Reset mid-burst discards all stored data.
- Accept rules, evaluated on pre-edge state:
  - rd_ok = read_en & ~fifo_empty.
  - wr_ok = write_en & (~fifo_full | rd_ok). A write while full is accepted only if a read is accepted in the same cycle.
- Write: on wr_ok, mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Read (default mode): on rd_ok, data_out <= mem[rd_ptr] and rd_ptr increments modulo DEPTH. Latency is 1 cycle. data_out holds its value when there is no accepted read.
- fill_count:
  - +1 on wr_ok & ~rd_ok
  - -1 on rd_ok & ~wr_ok
  - unchanged otherwise, including simultaneous accepted read and write
- Flags are registered and derived from the next fill_count, so they are exact in the cycle after the edge. No off-by-one is permitted.
- Simultaneous read and write when empty: write accepted, read rejected (underflow=1). fill_count becomes 1; data is readable next cycle.
- Simultaneous read and write when full: both accepted, fill_count stays DEPTH, overflow=0.
- overflow <= write_en & ~wr_ok; underflow <= read_en & ~rd_ok. Each is a pulse, not sticky.
- Ordering is strict FIFO. No data loss or duplication across pointer wrap-around.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN (first-word-fall-through).
- Defined:
  - data_out continuously presents mem[rd_ptr], the head entry, whenever fifo_empty=0. Zero read latency.
  - read_en acts as an acknowledge that pops the head; the next entry appears after the edge.
  - data_out is don't-care while fifo_empty=1. Accept rules, flags and counts are unchanged.
- Undefined: 1-cycle registered read as described in Behaviour.

Test Plan:
- Reset, then idle 3 cycles -> fifo_empty=1, almost_empty=1, fill_count=0, data_out=0, overflow=0, underflow=0.
- Write 0x01..0x10 (DEPTH=16) back-to-back -> almost_full rises after the 14th write, fifo_full=1 and fill_count=16 after the 16th; a 17th write 0xAA -> overflow pulses 1 cycle, fill_count stays 16.
- Drain 16 reads -> data_out sequence 0x01..0x10, each 1 cycle after its read (FWFT: same cycle); fifo_empty=1; a further read -> underflow pulse, data_out holds 0x10.
- Wrap: write 10, read 10, write 12, read 12 with random data -> order preserved across the pointer wrap; fill_count returns to 0.
- When full, assert read_en and write_en together for 5 cycles -> fill_count stays 16, no overflow; outputs are the oldest 5 entries, and the new data appears after the older entries drain.
- From empty, assert write_en and read_en together -> underflow=1, fill_count=1. Apply reset with 8 entries stored -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds and overflow/underflow pulses. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       write_en,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       read_en,
  output logic [DATA_W-1:0]          data_out,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     fill_count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              rd_ok;
  logic              wr_ok;
  logic [CNT_W-1:0]  count_next;

  // Accept decisions and next occupancy, all from pre-edge state.
  always_comb begin
    rd_ok      = read_en & ~fifo_empty;
    wr_ok      = write_en & (~fifo_full | rd_ok);
    count_next = fill_count;
    if (wr_ok && !rd_ok) begin
      count_next = fill_count + CNT_W'(1);
    end else if (rd_ok && !wr_ok) begin
      count_next = fill_count - CNT_W'(1);
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clock) begin
    if (wr_ok && !reset) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Count and flags are registered from the next count so they are exact after the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      fill_count   <= '0;
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      fill_count   <= count_next;
      fifo_full    <= (count_next == CNT_W'(DEPTH));
      fifo_empty   <= (count_next == CNT_W'(0));
      almost_full  <= (count_next >= CNT_W'(AF_LEVEL));
      almost_empty <= (count_next <= CNT_W'(AE_LEVEL));
      overflow     <= write_en & ~wr_ok;
      underflow    <= read_en & ~rd_ok;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is always presented; read_en only pops it.
  assign data_out = mem[rd_ptr];
`else
  // Registered read: data appears one cycle after an accepted read and holds otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out <= '0;
    end else if (rd_ok) begin
      data_out <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: queue-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_sync_fifo_param;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AF     = 14;
  localparam int unsigned AE     = 2;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              write_en = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              read_en = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              fifo_full, fifo_empty, almost_full, almost_empty;
  logic [CNT_W-1:0]  fill_count;
  logic              overflow, underflow;

  int total = 0;
  int bad   = 0;

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clock(clock), .reset(reset), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .data_out(data_out), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .fill_count(fill_count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO contents as a queue, updated at each rising edge.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] exp_dout = '0;
  bit                exp_ovf = 0, exp_unf = 0, model_valid = 0;

  always @(posedge clock) begin
    bit rd, wr;
    if (reset) begin
      q.delete();
      exp_dout = '0;
      exp_ovf = 0;
      exp_unf = 0;
      model_valid = 1;
    end else begin
      rd = read_en && (q.size() > 0);
      wr = write_en && ((q.size() < DEPTH) || rd);
      exp_ovf = write_en && !wr;
      exp_unf = read_en && !rd;
      if (rd) exp_dout = q.pop_front();
      if (wr) q.push_back(data_in);
    end
  end

  // Compare process: all outputs against the model on every falling edge.
  always @(negedge clock) begin
    if (model_valid) begin
      chk("m_count", 32'(fill_count), 32'(q.size()));
      chk("m_empty", 32'(fifo_empty), 32'(q.size() == 0));
      chk("m_full",  32'(fifo_full),  32'(q.size() == DEPTH));
      chk("m_afull", 32'(almost_full),  32'(q.size() >= AF));
      chk("m_aempty", 32'(almost_empty), 32'(q.size() <= AE));
      chk("m_ovf", 32'(overflow), 32'(exp_ovf));
      chk("m_unf", 32'(underflow), 32'(exp_unf));
`ifdef SYNC_FIFO_FWFT_EN
      if (q.size() > 0) chk("m_dout", 32'(data_out), 32'(q[0]));
`else
      chk("m_dout", 32'(data_out), 32'(exp_dout));
`endif
    end
  end

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic drive(input bit we, input logic [DATA_W-1:0] d, input bit re);
    write_en = we;
    data_in  = d;
    read_en  = re;
    @(posedge clock);
    #1;
  endtask

  logic [DATA_W-1:0] vals [DEPTH];
  logic [DATA_W-1:0] tmp;

  initial begin
    drive(0, '0, 0);
    drive(0, '0, 0);
    reset = 0;
    repeat (3) drive(0, '0, 0);
    chk("rst_count", 32'(fill_count), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_dout", 32'(data_out), 32'd0);
`endif

    // Fill to full, then overflow.
    for (int i = 1; i <= 16; i++) begin
      drive(1, DATA_W'(i), 0);
      if (i == 13) chk("af_before", 32'(almost_full), 32'd0);
      if (i == 14) chk("af_at14", 32'(almost_full), 32'd1);
      if (i == 15) chk("full_at15", 32'(fifo_full), 32'd0);
    end
    chk("full_at16", 32'(fifo_full), 32'd1);
    chk("count16", 32'(fill_count), 32'd16);
    drive(1, 8'hAA, 0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(fill_count), 32'd16);
    drive(0, '0, 0);
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Drain in order.
    for (int i = 1; i <= 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("drain_dout", 32'(data_out), 32'(i));
      drive(0, '0, 1);
`else
      drive(0, '0, 1);
      chk("drain_dout", 32'(data_out), 32'(i));
`endif
    end
    chk("drain_empty", 32'(fifo_empty), 32'd1);
    drive(0, '0, 1);
    chk("unf_pulse", 32'(underflow), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("unf_hold", 32'(data_out), 32'h10);
`endif

    // Pointer wrap with random data.
    repeat (10) drive(1, DATA_W'($urandom), 0);
    repeat (10) drive(0, '0, 1);
    repeat (12) drive(1, DATA_W'($urandom), 0);
    chk("wrap_count12", 32'(fill_count), 32'd12);
    repeat (12) drive(0, '0, 1);
    chk("wrap_count0", 32'(fill_count), 32'd0);

    // Full with simultaneous read and write.
    for (int i = 0; i < DEPTH; i++) begin
      vals[i] = DATA_W'($urandom);
      drive(1, vals[i], 0);
    end
    for (int k = 0; k < 5; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("rw_full_dout", 32'(data_out), 32'(vals[k]));
`endif
      tmp = DATA_W'($urandom);
      drive(1, tmp, 1);
`ifndef SYNC_FIFO_FWFT_EN
      chk("rw_full_dout", 32'(data_out), 32'(vals[k]));
`endif
      chk("rw_full_count", 32'(fill_count), 32'd16);
      chk("rw_full_ovf", 32'(overflow), 32'd0);
    end
    repeat (16) drive(0, '0, 1);
    chk("rw_full_drained", 32'(fifo_empty), 32'd1);

    // Simultaneous read and write when empty.
    drive(1, 8'h5C, 1);
    chk("rw_empty_unf", 32'(underflow), 32'd1);
    chk("rw_empty_count", 32'(fill_count), 32'd1);
    drive(0, '0, 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rw_empty_dout", 32'(data_out), 32'h5C);
`endif

    // Reset with 8 entries stored, while requests are active.
    repeat (8) drive(1, DATA_W'($urandom), 0);
    reset = 1;
    drive(1, 8'h77, 1);
    chk("mid_rst_count", 32'(fill_count), 32'd0);
    chk("mid_rst_empty", 32'(fifo_empty), 32'd1);
    chk("mid_rst_aempty", 32'(almost_empty), 32'd1);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("mid_rst_dout", 32'(data_out), 32'd0);
`endif
    reset = 0;

    // Random traffic, alternating write-heavy and read-heavy phases.
    for (int n = 0; n < 600; n++) begin
      if ((n / 100) % 2 == 0)
        drive(($urandom_range(0, 3) != 0), DATA_W'($urandom), ($urandom_range(0, 3) == 0));
      else
        drive(($urandom_range(0, 3) == 0), DATA_W'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (20) drive(0, '0, 1);

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
